// File: rtl/vend_pkg.sv
// Shared types for the candy vending controller: FSM state encoding,
// credit-register operations and the 2-bit transaction status codes.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCUM    = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ACC_HOLD = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2,
      ACC_CLR  = 2'd3
   } acc_op_t;

   localparam logic [1:0] ST_SALDO_INSUF = 2'b00;
   localparam logic [1:0] ST_TROCO_REC   = 2'b01;
   localparam logic [1:0] ST_DOCE_COMP   = 2'b10;
   localparam logic [1:0] ST_DOCE_TROCO  = 2'b11;

endpackage

// File: rtl/vend_controller_credit_acc.sv
// Credit register for the vending controller: add/subtract/clear under
// FSM control, plus coin acceptance (granularity, overflow) and zero flag.
module credit_acc
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int CHG_UNIT = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  acc_op_t             op_i,
   input  logic [CREDIT_W-1:0] operand_i,
   input  logic [CREDIT_W-1:0] coin_i,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                zero_o,
   output logic                coinOk_o
);

   localparam logic [CREDIT_W-1:0] UNIT_V = CREDIT_W'(CHG_UNIT);

   logic [CREDIT_W-1:0] credit_q;
   logic [CREDIT_W-1:0] credit_d;
   logic [CREDIT_W:0]   coinSum;

   // The extra sum bit is the overflow indicator for credit + coin.
   assign coinSum  = {1'b0, credit_q} + {1'b0, coin_i};
   assign coinOk_o = (coin_i != '0) && ((coin_i % UNIT_V) == '0) && !coinSum[CREDIT_W];
   assign zero_o   = (credit_q == '0);
   assign credit_o = credit_q;

   always_comb begin
      credit_d = credit_q;
      case (op_i)
         ACC_ADD:  credit_d = credit_q + operand_i;
         ACC_SUB:  credit_d = (operand_i > credit_q) ? '0 : credit_q - operand_i;
         ACC_CLR:  credit_d = '0;
         default:  credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q <= '0;
      end else begin
         credit_q <= credit_d;
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM: coin intake, buy arbitration, dispense and
// change handshakes. Define VEND_CANCEL_EN to add the cancel/refund input.
module vend_controller
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int PRICE    = 15,
   parameter int CHG_UNIT = 5
) (
   input  logic                c,
   input  logic                r,
   input  logic                coin_valid,
   input  logic [CREDIT_W-1:0] coin_val,
   output logic                coin_rej,
   input  logic                buy,
`ifdef VEND_CANCEL_EN
   input  logic                cancel,
`endif
   output logic                disp_req,
   input  logic                disp_ack,
   output logic                chg_req,
   input  logic                chg_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          status,
   output logic                done
);

   localparam logic [CREDIT_W-1:0] PRICE_V = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] UNIT_V  = CREDIT_W'(CHG_UNIT);

   state_t              state_q;
   logic [1:0]          status_q;
   logic                done_q;
   logic                coinRej_q;
   logic                dispReq_q;
   logic                chgReq_q;
   logic                purchase_q;

   acc_op_t             accOp;
   logic [CREDIT_W-1:0] accOperand;
   logic [CREDIT_W-1:0] creditVal;
   logic                creditZero;
   logic                coinOk;
   logic                creditGePrice;
   logic                lastUnit;
   logic                cancelIn;

`ifdef VEND_CANCEL_EN
   assign cancelIn = cancel;
`else
   assign cancelIn = 1'b0;
`endif

   assign creditGePrice = (creditVal >= PRICE_V);
   assign lastUnit      = (creditVal <= UNIT_V);

   credit_acc #(
      .CREDIT_W (CREDIT_W),
      .CHG_UNIT (CHG_UNIT)
   ) u_credit_acc (
      .clk       (c),
      .rst_n     (r),
      .op_i      (accOp),
      .operand_i (accOperand),
      .coin_i    (coin_val),
      .credit_o  (creditVal),
      .zero_o    (creditZero),
      .coinOk_o  (coinOk)
   );

   // Credit datapath control; must mirror the arbitration in the FSM below.
   always_comb begin
      accOp      = ACC_HOLD;
      accOperand = coin_val;
      case (state_q)
         IDLE, ACCUM: begin
            if (coin_valid) begin
               if (coinOk) accOp = ACC_ADD;
            end else if ((state_q == ACCUM) && !cancelIn && buy && creditGePrice) begin
               accOp      = ACC_SUB;
               accOperand = PRICE_V;
            end
         end
         CHANGE: begin
            if (chg_ack && !creditZero) begin
               accOp      = ACC_SUB;
               accOperand = UNIT_V;
            end
         end
         default: accOp = ACC_HOLD;
      endcase
   end

   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         state_q    <= IDLE;
         status_q   <= ST_SALDO_INSUF;
         done_q     <= 1'b0;
         coinRej_q  <= 1'b0;
         dispReq_q  <= 1'b0;
         chgReq_q   <= 1'b0;
         purchase_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         coinRej_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (coin_valid) begin
                  if (coinOk) state_q <= ACCUM;
                  else        coinRej_q <= 1'b1;
               end else if (cancelIn) begin
                  status_q <= ST_TROCO_REC;
                  done_q   <= 1'b1;
               end else if (buy) begin
                  status_q <= ST_SALDO_INSUF;
                  done_q   <= 1'b1;
               end
            end
            ACCUM: begin
               if (coin_valid) begin
                  if (!coinOk) coinRej_q <= 1'b1;
               end else if (cancelIn) begin
                  state_q    <= CHANGE;
                  chgReq_q   <= 1'b1;
                  purchase_q <= 1'b0;
               end else if (buy) begin
                  if (creditGePrice) begin
                     state_q    <= DISPENSE;
                     dispReq_q  <= 1'b1;
                     purchase_q <= 1'b1;
                  end else begin
                     status_q <= ST_SALDO_INSUF;
                     done_q   <= 1'b1;
                  end
               end
            end
            DISPENSE: begin
               if (coin_valid) coinRej_q <= 1'b1;
               if (disp_ack) begin
                  dispReq_q <= 1'b0;
                  if (creditZero) begin
                     state_q  <= IDLE;
                     status_q <= ST_DOCE_COMP;
                     done_q   <= 1'b1;
                  end else begin
                     state_q  <= CHANGE;
                     chgReq_q <= 1'b1;
                  end
               end
            end
            CHANGE: begin
               if (coin_valid) coinRej_q <= 1'b1;
               // The request drops on the same edge the final unit empties credit.
               if (chg_ack && lastUnit) begin
                  chgReq_q <= 1'b0;
                  state_q  <= IDLE;
                  status_q <= purchase_q ? ST_DOCE_TROCO : ST_TROCO_REC;
                  done_q   <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign coin_rej = coinRej_q;
   assign disp_req = dispReq_q;
   assign chg_req  = chgReq_q;
   assign credit   = creditVal;
   assign status   = status_q;
   assign done     = done_q;

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the candy vending machine datapath.
- Accepts coins into a credit register and arbitrates the buy request against the price.
- Drives the dispense mechanism and the change-return mechanism through req/ack handshakes.
- Reports each transaction outcome with the machine's 2-bit status codes: 00 saldo insuficiente, 01 troco recebido, 10 doce comprado, 11 doce e troco.

Parameters:
- CREDIT_W, 8: width of credit, coin value and price arithmetic.
- PRICE, 15: product price in currency units; must be a multiple of CHG_UNIT.
- CHG_UNIT, 5: value returned per change handshake; also the coin granularity.

Ports:
- c  in  1  clock, rising edge.
- r  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  one-cycle coin strobe.
- coin_val  in  CREDIT_W  coin value, sampled when coin_valid=1.
- coin_rej  out  1  one-cycle pulse: coin refused.
- buy  in  1  one-cycle purchase request.
- disp_req  out  1  dispense request, level.
- disp_ack  in  1  dispense done, one cycle.
- chg_req  out  1  change-unit request, level.
- chg_ack  in  1  one change unit released, one cycle.
- credit  out  CREDIT_W  current credit.
- status  out  2  last outcome code.
- done  out  1  one-cycle pulse when status updates.

Behaviour:
- Reset (r=0, async): state=IDLE; credit=0; status=00; done, coin_rej, disp_req, chg_req all 0. All outputs are registered.
- IDLE: credit is 0.
  - An accepted coin sets credit=coin_val and moves to ACCUM.
  - buy in IDLE -> status=00, done=1, stays IDLE.
- Coin acceptance (IDLE/ACCUM only):
  - Accepted only if coin_val≠0, coin_val is a multiple of CHG_UNIT, and credit+coin_val ≤ 2^CREDIT_W−1.
  - Otherwise coin_rej pulses the next cycle and credit is unchanged.
  - Coins in DISPENSE or CHANGE are always rejected.
  - Credit updates 1 cycle after coin_valid.
- ACCUM, on buy:
  - credit<PRICE -> status=00, done=1, stay ACCUM, credit kept.
  - credit≥PRICE -> credit−=PRICE, go to DISPENSE.
- Simultaneous coin_valid and buy: the coin is processed and buy is ignored.
- DISPENSE:
  - disp_req=1 from the cycle after the transition and held until disp_ack.
  - On disp_ack: disp_req=0. If credit=0 -> IDLE, status=10, done=1. Else -> CHANGE.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - chg_req=1 while credit>0.
  - Each chg_ack: credit−=CHG_UNIT.
  - When credit reaches 0: chg_req=0 the same cycle credit becomes 0, state=IDLE, done=1. Status is 11 after a purchase, 01 after a cancel.
  - chg_ack outside CHANGE is ignored.
- Latency example: buy with exact credit -> disp_req at +1 cycle; disp_ack at cycle N -> done/status at N+1.
- No wrap-around: credit never exceeds 2^CREDIT_W−1 and never goes negative.
- Reset mid-operation aborts any handshake, drops the request lines, and clears credit. Any pending dispense or change is lost.

Optional Feature:
- Macro VEND_CANCEL_EN.
- Defined: adds input port cancel (1 bit).
  - cancel in ACCUM -> go to CHANGE, refund full credit, finish with status=01.
  - cancel in IDLE -> status=01, done=1.
  - cancel elsewhere is ignored.
  - cancel has priority over buy in the same cycle; coin has priority over both.
- Not defined: no cancel port; status 01 is never produced.

Decomposition:
- Package vend_pkg:
  - state encoding IDLE=0, ACCUM=1, DISPENSE=2, CHANGE=3.
  - status constants ST_SALDO_INSUF=2'b00, ST_TROCO_REC=2'b01, ST_DOCE_COMP=2'b10, ST_DOCE_TROCO=2'b11.
- Sub-module credit_acc owns the credit register, the add/subtract/clear operations, the overflow and granularity checks, and the zero flag. The FSM in vend_controller drives its op select.

Test Plan:
- Reset asserted mid-DISPENSE (credit=5, disp_req=1) -> disp_req=0, credit=0, status=00, state IDLE immediately.
- Coins 10+5, buy -> disp_req at +1; disp_ack -> status=10, done pulse, credit=0, chg_req never asserted.
- Coins 10+10, buy, disp_ack -> chg_req=1, credit=5; one chg_ack -> credit=0, status=11, done.
- Coin 10, buy -> status=00, done, credit stays 10; coin_val=7 -> coin_rej, credit 10.
- credit=250, coin 10 -> coin_rej (overflow); coin during DISPENSE -> coin_rej; coin+buy same cycle -> credit increases, no disp_req.
- With VEND_CANCEL_EN: coins 25, cancel -> 5 chg_ack cycles, credit 0, status=01; without the macro the bench omits the cancel port.
